rv_fetch: RTL and testbench

Instruction-fetch stage that produces the PC stream consumed by the decode stage and drives the instruction-memory request bus. It holds the architectural fetch PC and advances it word by word. It accepts redirects (branch/jump target) from execute and honours pipeline stall. The memory returns data one cycle after an acked request, so o_pc/o_pc_p4 are presented in the same cycle as the address they describe. Decode registers them alongside the returned data.

---
 rtl/rv_fetch.sv | 116 +++++++++++
 tb/tb_rv_fetch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rv_fetch.sv
// rv_fetch: instruction-fetch stage.
// Holds the fetch PC, drives the instruction-memory request bus, and handles
// redirects from execute and pipeline stalls. The address on the bus stays
// stable until it is acked. A redirect that arrives while a request is pending
// is parked in r_target and applied once the bus accepts the old request.
module rv_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stall,
  input  logic        i_pc_sel,
  input  logic [31:2] i_pc_target,
  input  logic        i_bus_ack,
  output logic        o_bus_req,
  output logic [31:2] o_bus_addr,
  output logic [31:2] o_pc,
  output logic [31:2] o_pc_p4,
  output logic        o_stall_req
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_REDIR = 2'd3;

  logic [1:0]  r_state;
  logic [31:2] r_pc;
  logic [31:2] r_target;

  logic [1:0]  w_nextState;
  logic [31:2] w_nextPc;
  logic [31:2] w_nextTarget;
  logic [31:2] w_pcPlus1;

  assign w_pcPlus1 = r_pc + 30'd1;

  // Outputs depend only on state, r_pc and the ack, never on the redirect target
  always_comb begin
    o_bus_req   = 1'b0;
    o_stall_req = 1'b1;
    o_bus_addr  = r_pc;
    o_pc        = r_pc;
    o_pc_p4     = w_pcPlus1;
    case (r_state)
      ST_RUN: begin
        o_bus_req   = 1'b1;
        o_stall_req = !i_bus_ack;
      end
      ST_WAIT: begin
        o_bus_req   = 1'b1;
        o_stall_req = !i_bus_ack;
      end
      ST_REDIR: begin
        o_bus_req   = 1'b1;
        o_stall_req = 1'b1;
      end
      default: begin
        o_bus_req   = 1'b0;
        o_stall_req = 1'b1;
      end
    endcase
  end

  // Next-state and next-PC selection; a redirect always beats a stall
  always_comb begin
    w_nextState  = r_state;
    w_nextPc     = r_pc;
    w_nextTarget = r_target;
    case (r_state)
      ST_RESET: begin
        w_nextState = ST_RUN;
      end
      ST_RUN, ST_WAIT: begin
        if (i_bus_ack) begin
          w_nextState = ST_RUN;
          if (i_pc_sel) begin
            w_nextPc = i_pc_target;
          end else if (!i_stall) begin
            w_nextPc = w_pcPlus1;
          end
        end else if (i_pc_sel) begin
          w_nextTarget = i_pc_target;
          w_nextState  = ST_REDIR;
        end else begin
          w_nextState = ST_WAIT;
        end
      end
      ST_REDIR: begin
        if (i_bus_ack) begin
          w_nextState = ST_RUN;
          w_nextPc    = i_pc_sel ? i_pc_target : r_target;
        end else if (i_pc_sel) begin
          w_nextTarget = i_pc_target;
        end
      end
      default: begin
        w_nextState = ST_RESET;
      end
    endcase
  end

  // State registers with synchronous active-low reset that overrides any ack
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= ST_RESET;
      r_pc     <= RESET_VECTOR[31:2];
      r_target <= 30'd0;
    end else begin
      r_state  <= w_nextState;
      r_pc     <= w_nextPc;
      r_target <= w_nextTarget;
    end
  end

endmodule

// File: tb/tb_rv_fetch.sv
// tb_rv_fetch: directed self-checking bench for rv_fetch.
// Inputs change 1 ns after each rising edge and outputs are sampled 1 ns later.
module tb_rv_fetch;

  logic        clk;
  logic        resetN;
  logic        stall;
  logic        pcSel;
  logic [31:2] pcTarget;
  logic        busAck;
  logic        busReq;
  logic [31:2] busAddr;
  logic [31:2] pc;
  logic [31:2] pcP4;
  logic        stallReq;

  int testsRun;
  int testsFailed;

  rv_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
    .i_clk       (clk),
    .i_reset_n   (resetN),
    .i_stall     (stall),
    .i_pc_sel    (pcSel),
    .i_pc_target (pcTarget),
    .i_bus_ack   (busAck),
    .o_bus_req   (busReq),
    .o_bus_addr  (busAddr),
    .o_pc        (pc),
    .o_pc_p4     (pcP4),
    .o_stall_req (stallReq)
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then settle
  task automatic applyStimulus(input logic rn, input logic st, input logic sel,
                               input logic [31:2] tgt, input logic ack);
    @(posedge clk);
    #1;
    resetN   = rn;
    stall    = st;
    pcSel    = sel;
    pcTarget = tgt;
    busAck   = ack;
    #1;
  endtask

  // Check the outputs that describe the request on the bus this cycle
  task automatic checkFetch(input string tag, input logic [31:2] addr, input logic sreq);
    checkOutput({tag, "_req"},   {31'd0, busReq}, 32'd1);
    checkOutput({tag, "_addr"},  {2'b00, busAddr}, {2'b00, addr});
    checkOutput({tag, "_pc"},    {2'b00, pc}, {2'b00, addr});
    checkOutput({tag, "_pcp4"},  {2'b00, pcP4}, {2'b00, addr + 30'd1});
    checkOutput({tag, "_sreq"},  {31'd0, stallReq}, {31'd0, sreq});
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    resetN   = 1'b0;
    stall    = 1'b0;
    pcSel    = 1'b0;
    pcTarget = 30'd0;
    busAck   = 1'b1;

    // Reset held for three cycles with ack high: no request issued
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
      checkOutput("rst_req",  {31'd0, busReq}, 32'd0);
      checkOutput("rst_sreq", {31'd0, stallReq}, 32'd1);
      checkOutput("rst_addr", {2'b00, busAddr}, 32'd0);
      checkOutput("rst_pcp4", {2'b00, pcP4}, 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    checkOutput("rel_req", {31'd0, busReq}, 32'd0);

    // Sequential fetch from the reset vector
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
      checkFetch("seq", 30'(i), 1'b0);
    end

    // Redirect to 0x10, then two wait states
    applyStimulus(1'b1, 1'b0, 1'b1, 30'h10, 1'b1);
    checkFetch("redir10", 30'h4, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
    checkFetch("wait1", 30'h10, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
    checkFetch("wait2", 30'h10, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    checkFetch("waitAck", 30'h10, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 30'h20, 1'b1);
    checkFetch("afterWait", 30'h11, 1'b0);

    // Stall for three cycles at 0x20: address held four cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 30'd0, 1'b1);
      checkFetch("stall", 30'h20, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    checkFetch("stallLast", 30'h20, 1'b0);

    // Redirect with stall asserted together: redirect wins
    applyStimulus(1'b1, 1'b1, 1'b1, 30'h100, 1'b1);
    checkFetch("afterStall", 30'h21, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    checkFetch("redir100", 30'h100, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 30'h40, 1'b1);
    checkFetch("redir101", 30'h101, 1'b0);

    // Redirect while waiting: old address held, stall raised until resolved
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
    checkFetch("rw_a", 30'h40, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 30'h200, 1'b0);
    checkFetch("rw_b", 30'h40, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
    checkFetch("rw_c", 30'h40, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    checkFetch("rw_ack", 30'h40, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
    checkFetch("rw_new", 30'h200, 1'b1);

    // Second redirect before ack overwrites the parked target
    applyStimulus(1'b1, 1'b0, 1'b1, 30'h250, 1'b0);
    checkFetch("rw2_a", 30'h200, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 30'h300, 1'b0);
    checkFetch("rw2_b", 30'h200, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    checkFetch("rw2_ack", 30'h200, 1'b1);

    // Wrap-around of the word PC
    applyStimulus(1'b1, 1'b0, 1'b1, 30'h3FFF_FFFF, 1'b1);
    checkFetch("rw2_new", 30'h300, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    checkFetch("wrapTop", 30'h3FFF_FFFF, 1'b0);
    checkOutput("wrap_pcp4", {2'b00, pcP4}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    checkFetch("wrap0", 30'h0, 1'b0);

    // Reset in a wait-ack cycle: ack ignored, restart at the reset vector
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
    checkFetch("mr_wait", 30'h1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    checkFetch("mr_ack", 30'h1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    checkOutput("mr_req",  {31'd0, busReq}, 32'd0);
    checkOutput("mr_addr", {2'b00, busAddr}, 32'd0);
    checkOutput("mr_sreq", {31'd0, stallReq}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    checkOutput("mr_rel", {31'd0, busReq}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    checkFetch("mr_first", 30'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    checkFetch("mr_second", 30'h1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
